// File: rtl/dcache_line_memory_if.sv
// Line-transfer bus between the data-cache controller (master) and the line memory (slave).
// The master holds enable_i until ack_o pulses; data_o is valid while ack_o is high.
interface dcache_line_memory_if #(
  parameter int LINE_W = 256
);
  logic              enable_i;
  logic              write_i;
  logic [31:0]       addr_i;
  logic [LINE_W-1:0] data_i;
  logic              ack_o;
  logic [LINE_W-1:0] data_o;

  modport master (
    output enable_i, write_i, addr_i, data_i,
    input  ack_o, data_o
  );

  modport slave (
    input  enable_i, write_i, addr_i, data_i,
    output ack_o, data_o
  );
endinterface

// File: rtl/dcache_line_memory.sv
// Off-chip line memory model: one line read/write per request, ack LATENCY edges after accept.
// The request is latched on accept, so inputs are ignored and cannot stall it until the ack.
module dcache_line_memory #(
  parameter int LATENCY = 10,
  parameter int DEPTH   = 512,
  parameter int LINE_W  = 256
) (
  input logic                  clk_i,
  input logic                  rst_i,
  dcache_line_memory_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ack_q;
  logic [LINE_W-1:0] data_q;
  logic [LINE_W-1:0] wdat_q;
  logic [IDX_W-1:0]  idx_q;
  logic              wr_q;
  logic              commit;
  logic              unused_addr;

  logic [LINE_W-1:0] mem_q [DEPTH];

  assign bus.ack_o  = ack_q;
  assign bus.data_o = data_q;

  // Offset bits never select anything; upper bits alias onto the array.
  assign unused_addr = ^{bus.addr_i[4:0], bus.addr_i[31:5+IDX_W]};

  assign commit = (state_q == BUSY) && (cnt_q == '0) && wr_q;

  // The array is deliberately not reset; its contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (commit) begin
      mem_q[idx_q] <= wdat_q;
    end
  end

  // LATENCY=1 loads a zero count, so BUSY lasts a single edge and the ack
  // still lands exactly one edge after accept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      data_q  <= '0;
      wdat_q  <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= 1'b0;
          if (bus.enable_i) begin
            idx_q   <= bus.addr_i[5 +: IDX_W];
            wr_q    <= bus.write_i;
            wdat_q  <= bus.data_i;
            cnt_q   <= CNT_W'(LATENCY - 1);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            ack_q   <= 1'b1;
            state_q <= ACK;
            if (!wr_q) begin
              data_q <= mem_q[idx_q];
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ACK: begin
          ack_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          ack_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_line_memory.sv
// Bench for dcache_line_memory: table of line requests on a LATENCY=10 instance, hand sequences
// for back-to-back, async reset and a LATENCY=1/DEPTH=16 instance; scoreboard checks every ack.
module tb_dcache_line_memory;
  typedef logic [255:0] line_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    line_t       wdat;
    line_t       exp;
  } vec_t;

  typedef struct {
    int    dut;
    int    due;
    line_t data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic        en   [2];
  logic        wr   [2];
  logic [31:0] addr [2];
  line_t       wdat [2];
  logic        ack  [2];
  line_t       dat  [2];
  logic        prev_ack [2];

  exp_t sbq[$];
  vec_t tbl[8];

  dcache_line_memory_if #(.LINE_W(256)) bus0 ();
  dcache_line_memory_if #(.LINE_W(256)) bus1 ();

  dcache_line_memory #(.LATENCY(10), .DEPTH(512), .LINE_W(256)) dut0 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus0)
  );

  dcache_line_memory #(.LATENCY(1), .DEPTH(16), .LINE_W(256)) dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus1)
  );

  assign bus0.enable_i = en[0];
  assign bus0.write_i  = wr[0];
  assign bus0.addr_i   = addr[0];
  assign bus0.data_i   = wdat[0];
  assign bus1.enable_i = en[1];
  assign bus1.write_i  = wr[1];
  assign bus1.addr_i   = addr[1];
  assign bus1.data_i   = wdat[1];
  assign ack[0] = bus0.ack_o;
  assign ack[1] = bus1.ack_o;
  assign dat[0] = bus0.data_o;
  assign dat[1] = bus1.data_o;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input bit ok, input string name, input line_t act, input line_t exp);
    checks = checks + 1;
    if (!ok) begin
      failures = failures + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every ack must match the oldest outstanding request.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        prev_ack[d] = 1'b0;
      end else begin
        if (prev_ack[d]) begin
          chk(ack[d] == 1'b0, "ack_width", line_t'(ack[d]), '0);
        end else if (ack[d]) begin
          bit   ok;
          exp_t e;
          ok = (sbq.size() != 0) && (sbq[0].dut == d);
          chk(ok, "ack_expected", line_t'(d), line_t'(sbq.size()));
          if (ok) begin
            e = sbq.pop_front();
            chk(cyc == e.due, "ack_cycle", line_t'(cyc), line_t'(e.due));
            chk(dat[d] == e.data, "data_o", dat[d], e.data);
          end
        end
        prev_ack[d] = ack[d];
      end
    end
  end

  // Called at a negedge; returns at the negedge on which ack is seen.
  task automatic do_req(input int d, input bit w, input logic [31:0] a, input line_t wd,
                        input line_t ed, input int lat, input bit after_ack, input bit hold,
                        output int ack_at);
    exp_t e;
    int   n;
    en[d]   = 1'b1;
    wr[d]   = w;
    addr[d] = a;
    wdat[d] = wd;
    e.dut  = d;
    e.due  = cyc + (after_ack ? 2 : 1) + lat;
    e.data = ed;
    sbq.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n = n + 1;
    end while (!ack[d] && n < 100);
    chk(ack[d] == 1'b1, "ack_seen", line_t'(n), line_t'(lat));
    ack_at = cyc;
    if (!hold) begin
      en[d] = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int    t1;
    int    t2;
    bit    any_ack;
    line_t a5, db, l9, l7, l5, l1;

    a5 = {8{32'hA5A5_0003}};
    db = {8{32'hDEAD_BEEF}};
    l9 = {8{32'h0909_0909}};
    l7 = {8{32'h0707_0707}};
    l5 = {8{32'h0505_0505}};
    l1 = {8{32'h1111_0001}};

    tbl[0] = '{1'b1, 32'h0000_0060, a5, '0};
    tbl[1] = '{1'b0, 32'h0000_0060, '0, a5};
    tbl[2] = '{1'b1, 32'h0000_041F, db, a5};
    tbl[3] = '{1'b0, 32'h0000_0400, '0, db};
    tbl[4] = '{1'b1, 32'h0000_0120, l9, db};
    tbl[5] = '{1'b1, 32'h0000_00E0, l7, db};
    tbl[6] = '{1'b0, 32'h0000_4060, '0, a5};
    tbl[7] = '{1'b0, 32'h0000_007F, '0, a5};

    for (int d = 0; d < 2; d++) begin
      en[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wdat[d] = '0; prev_ack[d] = 1'b0;
    end

    #1;
    chk(ack[0] == 1'b0, "reset_ack", line_t'(ack[0]), '0);
    chk(dat[0] == '0, "reset_data", dat[0], '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      do_req(0, tbl[i].wr, tbl[i].addr, tbl[i].wdat, tbl[i].exp, 10, 1'b0, 1'b0, t1);
      @(negedge clk);
    end

    // Write-back of line 5 then refill of line 7 with enable held across the ack.
    do_req(0, 1'b1, 32'h0000_00A0, l5, a5, 10, 1'b0, 1'b1, t1);
    do_req(0, 1'b0, 32'h0000_00E0, '0, l7, 10, 1'b1, 1'b0, t2);
    chk(t2 - t1 == 12, "b2b_span", line_t'(t2 - t1), line_t'(12));
    @(negedge clk);
    do_req(0, 1'b0, 32'h0000_00A0, '0, l5, 10, 1'b0, 1'b0, t1);
    @(negedge clk);

    // Abandon a write to line 9 five cycles in; reset lands mid-cycle.
    en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h0000_0120; wdat[0] = {8{32'hFFFF_0000}};
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk(ack[0] == 1'b0, "async_rst_ack", line_t'(ack[0]), '0);
    chk(dat[0] == '0, "async_rst_data", dat[0], '0);
    @(negedge clk);
    en[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    any_ack = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (ack[0]) any_ack = 1'b1;
    end
    chk(any_ack == 1'b0, "no_ack_after_rst", line_t'(any_ack), '0);
    do_req(0, 1'b0, 32'h0000_0120, '0, l9, 10, 1'b0, 1'b0, t1);
    @(negedge clk);

    // LATENCY=1, DEPTH=16: index 17 wraps to line 1.
    do_req(1, 1'b1, 32'h0000_0020, l1, '0, 1, 1'b0, 1'b0, t1);
    @(negedge clk);
    do_req(1, 1'b0, 32'h0000_0220, '0, l1, 1, 1'b0, 1'b0, t1);
    repeat (3) @(negedge clk);

    chk(sbq.size() == 0, "sb_empty", line_t'(sbq.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
